// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR comparator controller.
// The state enum, default sizing and the comparator synchronizer depth live here.
package sar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    SETTLE,
    DECIDE,
    DONE
  } state_t;

  localparam int NBITS_DEF       = 8;
  localparam int SAMPLE_CYC_DEF  = 2;
  localparam int SETTLE_CYC_DEF  = 4;
  localparam int CMP_SYNC_STAGES = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sar_cmp_sync.sv
// Multi-flop synchronizer for the asynchronous latch-comparator decision.
// Only instantiated when SAR_CMP_SYNC_EN is defined.
module sar_cmp_sync
  import sar_pkg::*;
#(
  parameter int STAGES = CMP_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sar_comp_ctrl.sv
// Successive-approximation controller driving the reference DAC and sampling the latch comparator.
// Optional macro SAR_CMP_SYNC_EN adds a synchronizer on cmp_in and stretches each settle window to match.
module sar_comp_ctrl
  import sar_pkg::*;
#(
  parameter int NBITS      = NBITS_DEF,
  parameter int SAMPLE_CYC = SAMPLE_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_in,
  output logic             sample,
  output logic [NBITS-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] result
);

`ifdef SAR_CMP_SYNC_EN
  localparam int SETTLE_LEN = SETTLE_CYC + CMP_SYNC_STAGES;
`else
  localparam int SETTLE_LEN = SETTLE_CYC;
`endif

  localparam int CNT_W = $clog2(max2(SAMPLE_CYC, SETTLE_LEN)) + 1;
  localparam int BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [BIT_W-1:0] BIT_TOP     = BIT_W'(NBITS - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);
  localparam logic [NBITS-1:0] MSB_TRIAL   = NBITS'(1) << (NBITS - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [BIT_W-1:0]   bit_m1;
  logic [NBITS-1:0]   code_q, code_d;
  logic [NBITS-1:0]   result_q, result_d;
  logic               cmp_dec;

`ifdef SAR_CMP_SYNC_EN
  sar_cmp_sync #(
    .STAGES(CMP_SYNC_STAGES)
  ) u_cmp_sync (
    .clk(clk),
    .rst(rst),
    .d  (cmp_in),
    .q  (cmp_dec)
  );
`else
  assign cmp_dec = cmp_in;
`endif

  assign bit_m1 = bit_q - BIT_W'(1);

  // Abort preempts every non-IDLE transition; in IDLE it only masks start.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    code_d   = code_q;
    result_d = result_q;

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = BIT_TOP;
      code_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d  = '0;
          code_d = '0;
          if (start && !abort) begin
            state_d = SAMPLE;
          end
        end
        SAMPLE: begin
          if (cnt_q == SAMPLE_LAST) begin
            cnt_d   = '0;
            code_d  = MSB_TRIAL;
            state_d = SETTLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = DECIDE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DECIDE: begin
          code_d[bit_q] = code_q[bit_q] & cmp_dec;
          if (bit_q != '0) begin
            code_d[bit_m1] = 1'b1;
            bit_d          = bit_m1;
            state_d        = SETTLE;
          end else begin
            result_d = code_d;
            state_d  = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
          code_d  = '0;
          bit_d   = BIT_TOP;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          bit_d   = BIT_TOP;
          code_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= BIT_TOP;
      code_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      code_q   <= code_d;
      result_q <= result_d;
    end
  end

  assign sample   = (state_q == SAMPLE);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign dac_code = code_q;
  assign result   = result_q;

endmodule
